lcd_bus_driver: RTL and testbench
=================================

// Module: lcd_bus_driver
// PURPOSE
//  HD44780-style character-LCD bus timing engine. Sits directly downstream of the
//  init/text sequencer FSM: accepts one 8-bit byte plus RS per start strobe and drives
//  LCD_DATA/RS/RW/EN/ON with setup, enable-pulse, hold and post-command execution delays.
//  Signals completion with a one-cycle done pulse so the sequencer can advance its LUT index.
// PARAMETERS
//  T_SETUP       4      cycles data/RS stable before EN rises (>=1)
//  T_EN          16     cycles EN held high (>=1)
//  T_HOLD        4      cycles data/RS held after EN falls (>=1)
//  T_EXEC_SHORT  2500   post-write execution wait, normal commands/data (50 us @ 50 MHz, >=1)
//  T_EXEC_LONG   82000  post-write execution wait, clear/home commands (1.64 ms @ 50 MHz, >=1)
//  CNT_W         18     phase-counter width; must hold max(all T_*) - 1
// PORTS
//  clk       in   1  system clock; all logic on rising edge
//  reset     in   1  synchronous, active-high reset
//  start     in   1  request strobe; accepted only when busy==0
//  iDATA     in   8  byte to write; sampled on the accepting edge
//  iRS       in   1  0 = instruction, 1 = data; sampled on the accepting edge
//  busy      out  1  1 while a transfer is in flight
//  LCD_DONE  out  1  one-cycle pulse when the transfer and its exec wait are complete
//  LCD_DATA  out  8  LCD data bus
//  LCD_RS    out  1  LCD register select
//  LCD_RW    out  1  LCD read/write; tied 0 (write only)
//  LCD_EN    out  1  LCD enable strobe
//  LCD_ON    out  1  LCD power enable; constant 1
// BEHAVIOUR
//  Reset values: state=IDLE, counter=0, busy=0, LCD_DONE=0, LCD_DATA=0, LCD_RS=0,
//    LCD_EN=0, LCD_RW=0, LCD_ON=1. All outputs are registered.
//  FSM: IDLE -> SETUP -> EN_HIGH -> HOLD -> EXEC -> IDLE.
//  IDLE: busy=0, EN=0. On start=1, latch iDATA->LCD_DATA and iRS->LCD_RS, select the exec
//    length, clear the counter, go to SETUP.
//    - The start level matters; there is no edge detect. If start is held high, a new
//      transfer is accepted on every cycle spent in IDLE.
//  SETUP:   T_SETUP cycles, EN=0.
//  EN_HIGH: T_EN cycles, EN=1.
//  HOLD:    T_HOLD cycles, EN=0, data/RS unchanged.
//  EXEC:    T_EXEC cycles, then return to IDLE. On the edge entering IDLE, assert LCD_DONE=1
//    for exactly one cycle.
//  Phase exit: each phase counts 0..T-1 and exits when count==T-1; the counter resets
//    to 0 on every phase change.
//  busy=1 from the accepting edge through the last EXEC cycle. busy=0 in the LCD_DONE cycle.
//  Exec length: use T_EXEC_LONG when iRS==0 and iDATA[7:2]==0 and iDATA!=0
//    (i.e. 0x01 clear, 0x02/0x03 home). Otherwise use T_EXEC_SHORT.
//  Latency: the accepting edge is edge k. LCD_DONE is high in the cycle after edge
//    k+T_SETUP+T_EN+T_HOLD+T_EXEC. EN rises on edge k+T_SETUP.
//  start while busy=1: ignored, no queuing. LCD_DATA/RS do not change mid-transfer.
//  start during the LCD_DONE cycle: accepted (state is IDLE), so back-to-back transfers
//    run with no gap.
//  After the transfer, LCD_DATA/RS keep their last values until the next accept.
//  reset during any state: next edge forces the reset values (EN low immediately),
//    no LCD_DONE pulse, and the in-flight byte is dropped.
//  Counter never wraps: it is bounded by the phase compare. A CNT_W too small is a
//    configuration error, to be caught by an elaboration assertion.
// TESTING
//  1 Data write: iRS=1, iDATA=0x57, start 1 cycle -> LCD_RS=1, LCD_DATA=0x57.
//    EN high for exactly 16 cycles starting 4 cycles after the accept.
//    LCD_DONE 1 cycle, 2524 cycles after the accept.
//  2 Clear command: iRS=0, iDATA=0x01 -> long exec. LCD_DONE at 82024 cycles, busy high
//    throughout. Repeat with 0x38 -> LCD_DONE at 2524.
//  3 Ignored start: start with 0x41, then start with 0x42 at cycle 10 -> LCD_DATA stays 0x41.
//    Exactly one LCD_DONE pulse.
//  4 Back-to-back: start held high, sequencer supplies 0x38, 0x0C, 0x01 -> three
//    EN pulses and three LCD_DONE pulses, with exec waits of 2500, 2500 and 82000 cycles.
//  5 Reset mid-pulse: assert reset on cycle 8 of EN_HIGH -> next edge EN=0, busy=0,
//    LCD_DATA=0, LCD_ON=1, no LCD_DONE. A new start afterwards completes normally.
//  6 Invariants, checked on every cycle: LCD_RW==0; LCD_ON==1; LCD_DATA/RS stable
//    whenever busy=1; LCD_DONE never high on two consecutive cycles.

Source files
------------

// File: rtl/lcd_bus_driver.sv
// HD44780-style character-LCD bus timing engine.
// Takes one byte plus RS per accepted start. It drives the LCD bus with setup,
// enable-pulse, hold and execution-wait phases, then pulses LCD_DONE for one
// cycle so the upstream sequencer can advance.
module lcd_bus_driver #(
  parameter int T_SETUP      = 4,
  parameter int T_EN         = 16,
  parameter int T_HOLD       = 4,
  parameter int T_EXEC_SHORT = 2500,
  parameter int T_EXEC_LONG  = 82000,
  parameter int CNT_W        = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] iDATA,
  input  logic       iRS,
  output logic       busy,
  output logic       LCD_DONE,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_ON
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETUP   = 3'd1;
  localparam logic [2:0] EN_HIGH = 3'd2;
  localparam logic [2:0] HOLD    = 3'd3;
  localparam logic [2:0] EXEC    = 3'd4;

  // Longest phase decides how wide the shared phase counter must be.
  localparam longint T_MAX_A = (T_SETUP > T_EN) ? T_SETUP : T_EN;
  localparam longint T_MAX_B = (T_HOLD > T_EXEC_SHORT) ? T_HOLD : T_EXEC_SHORT;
  localparam longint T_MAX_C = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam longint T_MAX   = (T_MAX_C > T_EXEC_LONG) ? T_MAX_C : T_EXEC_LONG;

  generate
    if (T_SETUP < 1 || T_EN < 1 || T_HOLD < 1 || T_EXEC_SHORT < 1 || T_EXEC_LONG < 1) begin : gBadTiming
      $error("lcd_bus_driver: every phase length must be at least 1 cycle");
    end
    if (CNT_W < 1 || CNT_W > 62 || (T_MAX - 1) >= (64'sd1 <<< CNT_W)) begin : gCntTooSmall
      $error("lcd_bus_driver: CNT_W cannot hold the longest phase count");
    end
  endgenerate

  // Terminal count of each phase; a phase ends when the counter reaches it.
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(T_EN - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(T_EXEC_SHORT - 1);
  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(T_EXEC_LONG - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] phaseLast;
  logic             phaseEnd;
  logic             execLong;
  logic             isSlowCmd;

  // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
  assign isSlowCmd = !iRS && (iDATA[7:2] == 6'd0) && (iDATA != 8'd0);

  // Select the terminal count for the current phase.
  always_comb begin
    phaseLast = '0;
    case (state)
      SETUP:   phaseLast = SETUP_LAST;
      EN_HIGH: phaseLast = EN_LAST;
      HOLD:    phaseLast = HOLD_LAST;
      EXEC:    phaseLast = execLong ? LONG_LAST : SHORT_LAST;
      default: phaseLast = '0;
    endcase
  end

  assign phaseEnd = (cnt == phaseLast);

  // Transfer sequencer: phase walk, bus outputs and completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      execLong <= 1'b0;
      busy     <= 1'b0;
      LCD_DONE <= 1'b0;
      LCD_DATA <= 8'd0;
      LCD_RS   <= 1'b0;
      LCD_RW   <= 1'b0;
      LCD_EN   <= 1'b0;
      LCD_ON   <= 1'b1;
    end else begin
      LCD_DONE <= 1'b0;
      // The counter restarts on every phase change and is held at 0 in IDLE.
      cnt <= (state == IDLE || phaseEnd) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            LCD_DATA <= iDATA;
            LCD_RS   <= iRS;
            execLong <= isSlowCmd;
            busy     <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (phaseEnd) begin
            LCD_EN <= 1'b1;
            state  <= EN_HIGH;
          end
        end
        EN_HIGH: begin
          if (phaseEnd) begin
            LCD_EN <= 1'b0;
            state  <= HOLD;
          end
        end
        HOLD: begin
          if (phaseEnd) state <= EXEC;
        end
        EXEC: begin
          if (phaseEnd) begin
            busy     <= 1'b0;
            LCD_DONE <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          busy   <= 1'b0;
          LCD_EN <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Bench for lcd_bus_driver. It uses shortened phase lengths so that long
// commands stay cheap. A reference model turns every accepted start into
// expected bus windows and a scoreboard entry. A monitor checks each cycle
// and pops the scoreboard on every LCD_DONE.
module tb_lcd_bus_driver;

  localparam int TS  = 4;
  localparam int TEN = 16;
  localparam int TH  = 4;
  localparam int TXS = 40;
  localparam int TXL = 150;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] iDATA;
  logic       iRS;
  logic       busy, LCD_DONE, LCD_RS, LCD_RW, LCD_EN, LCD_ON;
  logic [7:0] LCD_DATA;

  always #5 clk = ~clk;

  lcd_bus_driver #(
    .T_SETUP(TS), .T_EN(TEN), .T_HOLD(TH),
    .T_EXEC_SHORT(TXS), .T_EXEC_LONG(TXL), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .iDATA(iDATA), .iRS(iRS),
    .busy(busy), .LCD_DONE(LCD_DONE), .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS),
    .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .LCD_ON(LCD_ON)
  );

  int nChecks = 0;
  int nFails  = 0;
  int edgeN   = 0;
  int doneCnt = 0;
  int enRises = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      if (nFails <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edgeN);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         doneAt;
    logic [7:0] d;
    logic       rs;
  } xfer_t;

  xfer_t      doneQ[$];
  bit         active = 1'b0;
  int         accK   = 0;
  int         lenK   = 0;
  logic [7:0] mData  = 8'd0;
  logic       mRs    = 1'b0;

  // A transfer is in flight from edge accK up to edge accK+total. The next
  // accept can only happen on a later edge.
  function automatic int totalLen();
    return TS + TEN + TH + lenK;
  endfunction

  function automatic bit modelBusy(input int e);
    return active && e >= accK && e < accK + totalLen();
  endfunction

  always @(posedge clk) begin
    edgeN++;
    if (reset) begin
      active = 1'b0;
      mData  = 8'd0;
      mRs    = 1'b0;
      doneQ.delete();
    end else if (start && (!active || edgeN > accK + totalLen())) begin
      lenK   = (!iRS && iDATA >= 8'd1 && iDATA <= 8'd3) ? TXL : TXS;
      accK   = edgeN;
      active = 1'b1;
      mData  = iDATA;
      mRs    = iRS;
      doneQ.push_back(xfer_t'{edgeN + totalLen(), iDATA, iRS});
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic       prevDone = 1'b0;
  logic       prevBusy = 1'b0;
  logic       prevEn   = 1'b0;
  logic [7:0] prevData = 8'd0;
  logic       prevRs   = 1'b0;
  xfer_t      got;
  bit         expEn;

  always @(negedge clk) begin
    expEn = active && edgeN >= accK + TS && edgeN < accK + TS + TEN;
    chk("busy", busy, modelBusy(edgeN));
    chk("lcd_en", LCD_EN, expEn);
    chk("lcd_data", LCD_DATA, mData);
    chk("lcd_rs", LCD_RS, mRs);
    chk("lcd_rw", LCD_RW, 1'b0);
    chk("lcd_on", LCD_ON, 1'b1);
    if (prevBusy && busy) chk("data_rs_stable", {LCD_RS, LCD_DATA}, {prevRs, prevData});
    if (LCD_EN && !prevEn) enRises++;
    if (LCD_DONE === 1'b1) begin
      chk("done_single_cycle", prevDone, 1'b0);
      if (doneQ.size() == 0) begin
        chk("unexpected_done", 1'b1, 1'b0);
      end else begin
        got = doneQ.pop_front();
        chk("done_edge", edgeN, got.doneAt);
        chk("done_data", LCD_DATA, got.d);
        chk("done_rs", LCD_RS, got.rs);
        doneCnt++;
      end
    end else if (doneQ.size() > 0 && edgeN >= doneQ[0].doneAt) begin
      chk("missing_done", edgeN, doneQ[0].doneAt + 1);
      void'(doneQ.pop_front());
    end
    prevDone = LCD_DONE;
    prevBusy = busy;
    prevEn   = LCD_EN;
    prevData = LCD_DATA;
    prevRs   = LCD_RS;
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] d, input logic rs);
    @(negedge clk);
    start = 1'b1; iDATA = d; iRS = rs;
    @(negedge clk);
    start = 1'b0; iDATA = 8'($urandom); iRS = 1'($urandom);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((modelBusy(edgeN) || doneQ.size() != 0 || busy) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_timeout", n >= 1000, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  logic [7:0] seq [3];
  int d0, e0, idx, n;

  initial begin
    reset = 1'b1; start = 1'b0; iDATA = 8'd0; iRS = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", LCD_DONE, 1'b0);
    chk("reset_data", LCD_DATA, 8'd0);
    chk("reset_en", LCD_EN, 1'b0);
    chk("reset_on", LCD_ON, 1'b1);
    reset = 1'b0;

    // Data write and exec-length selection across the boundaries.
    send(8'h57, 1'b1);
    chk("data_write_rs", LCD_RS, 1'b1);
    chk("data_write_data", LCD_DATA, 8'h57);
    waitIdle();
    send(8'h01, 1'b0); waitIdle();
    send(8'h38, 1'b0); waitIdle();
    send(8'h02, 1'b0); waitIdle();
    send(8'h03, 1'b0); waitIdle();
    send(8'h04, 1'b0); waitIdle();
    send(8'h00, 1'b0); waitIdle();
    send(8'h01, 1'b1); waitIdle();

    // A start while busy is ignored.
    d0 = doneCnt;
    send(8'h41, 1'b1);
    repeat (8) @(negedge clk);
    send(8'h42, 1'b1);
    waitIdle();
    chk("ignored_start_data", LCD_DATA, 8'h41);
    chk("ignored_start_dones", doneCnt - d0, 1);

    // Back-to-back: start held high, the next byte is supplied in each done cycle.
    seq[0] = 8'h38; seq[1] = 8'h0C; seq[2] = 8'h01;
    d0 = doneCnt; e0 = enRises; idx = 0; n = 0;
    @(negedge clk);
    start = 1'b1; iDATA = seq[0]; iRS = 1'b0;
    while (idx < 3 && n < 1000) begin
      @(negedge clk);
      n++;
      if (LCD_DONE === 1'b1) begin
        idx++;
        if (idx == 3) start = 1'b0;
        else iDATA = seq[idx];
      end
    end
    chk("b2b_timeout", n >= 1000, 1'b0);
    waitIdle();
    chk("b2b_dones", doneCnt - d0, 3);
    chk("b2b_en_pulses", enRises - e0, 3);

    // Reset on the 8th EN_HIGH cycle drops the transfer.
    send(8'h48, 1'b1);
    repeat (TS + 7) @(negedge clk);
    chk("pre_reset_en", LCD_EN, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset_en", LCD_EN, 1'b0);
    chk("mid_reset_busy", busy, 1'b0);
    chk("mid_reset_data", LCD_DATA, 8'd0);
    chk("mid_reset_on", LCD_ON, 1'b1);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    d0 = doneCnt;
    send(8'h0C, 1'b0);
    waitIdle();
    chk("after_reset_dones", doneCnt - d0, 1);

    // Random traffic: start level, data, RS and rare resets all random.
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      iRS   = 1'($urandom);
      iDATA = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      reset = ($urandom_range(0, 799) == 0);
    end
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    waitIdle();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
